ysyx_25030081_lsu: RTL and testbench

Load/store unit of the NPC core. It sits directly downstream of the decoder/execute path and consumes the decoded memory-control bundle (`mem_ren`, `mem_wen`, `mem_op`), the ALU-computed address and the rs2 store data. It runs one multi-cycle transaction on a simple req/gnt/rvalid data bus and hands an aligned, extended load result to writeback over a valid/ready handshake.

---
 rtl/ysyx_25030081_lsu_pkg.sv | 37 +++
 rtl/ysyx_25030081_lsu_align.sv | 58 +++++
 rtl/ysyx_25030081_lsu.sv | 154 +++++++++++++++
 tb/tb_ysyx_25030081_lsu.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25030081_lsu_pkg.sv
// Shared LSU definitions: mem_op field layout, access-size decode and FSM state encoding.
package ysyx_25030081_lsu_pkg;

  localparam int MEM_OP_W        = 3;
  localparam int MEM_OP_UNS_BIT  = 2;
  localparam int MEM_OP_WORD_BIT = 1;
  localparam int MEM_OP_HALF_BIT = 0;

  localparam logic [MEM_OP_W-1:0] MEM_OP_LB  = 3'b000;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LH  = 3'b001;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LW  = 3'b010;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LBU = 3'b100;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LHU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  // The word bit dominates, so the unused codes 011 and 11x decode as word.
  function automatic mem_size_e op_size(input logic [MEM_OP_W-1:0] op);
    mem_size_e sz;
    if (op[MEM_OP_WORD_BIT])      sz = SZ_WORD;
    else if (op[MEM_OP_HALF_BIT]) sz = SZ_HALF;
    else                          sz = SZ_BYTE;
    return sz;
  endfunction

endpackage

// File: rtl/ysyx_25030081_lsu_align.sv
// Combinational lane logic: store strobes/data/misalign from the live request,
// load extraction and extension from the captured op and offset.
module ysyx_25030081_lsu_align
  import ysyx_25030081_lsu_pkg::*;
(
  input  logic [MEM_OP_W-1:0] st_op_i,
  input  logic [1:0]          st_off_i,
  input  logic [31:0]         st_wdata_i,
  output logic [3:0]          st_wstrb_o,
  output logic [31:0]         st_wdata_o,
  output logic                st_misalign_o,
  input  logic [MEM_OP_W-1:0] ld_op_i,
  input  logic [1:0]          ld_off_i,
  input  logic [31:0]         ld_rdata_i,
  output logic [31:0]         ld_data_o
);

  mem_size_e   st_size;
  mem_size_e   ld_size;
  logic [31:0] ld_shifted;
  logic        ld_signed;

  always_comb begin
    st_size       = op_size(st_op_i);
    st_wstrb_o    = 4'b1111;
    st_wdata_o    = st_wdata_i;
    st_misalign_o = 1'b0;
    case (st_size)
      SZ_BYTE: begin
        st_wstrb_o = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        st_wstrb_o    = 4'b0011 << st_off_i;
        st_wdata_o    = {2{st_wdata_i[15:0]}};
        st_misalign_o = st_off_i[0];
      end
      default: begin
        st_wstrb_o    = 4'b1111;
        st_wdata_o    = st_wdata_i;
        st_misalign_o = |st_off_i;
      end
    endcase
  end

  always_comb begin
    ld_size    = op_size(ld_op_i);
    ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
    ld_signed  = ~ld_op_i[MEM_OP_UNS_BIT];
    ld_data_o  = ld_shifted;
    case (ld_size)
      SZ_BYTE: ld_data_o = {{24{ld_signed & ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_HALF: ld_data_o = {{16{ld_signed & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_data_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_25030081_lsu.sv
// NPC load/store unit: one req/gnt/rvalid bus transaction per instruction,
// result held for writeback under a valid/ready handshake.
//
// state | meaning
// IDLE  | ready for a new instruction (in_ready = 1)
// REQ   | bus_req high, address/strobes/data held until bus_gnt
// WAIT  | granted, waiting for bus_rvalid
// DONE  | out_valid high, result held until out_ready
module ysyx_25030081_lsu
  import ysyx_25030081_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mem_ren,
  input  logic                mem_wen,
  input  logic [MEM_OP_W-1:0] mem_op,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [31:0]         wdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_rdata,
  output logic                out_misalign,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [3:0]          bus_wstrb,
  output logic [31:0]         bus_wdata,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [31:0]         bus_rdata
);

  lsu_state_e          state_q, state_d;
  logic [MEM_OP_W-1:0] op_q, op_d;
  logic [1:0]          off_q, off_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                misalign_q, misalign_d;

  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic        st_misalign;
  logic [31:0] ld_data;

  ysyx_25030081_lsu_align u_align (
    .st_op_i       (mem_op),
    .st_off_i      (addr[1:0]),
    .st_wdata_i    (wdata),
    .st_wstrb_o    (st_wstrb),
    .st_wdata_o    (st_wdata),
    .st_misalign_o (st_misalign),
    .ld_op_i       (op_q),
    .ld_off_i      (off_q),
    .ld_rdata_i    (bus_rdata),
    .ld_data_o     (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LSU_IDLE;
      op_q       <= '0;
      off_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      off_q      <= off_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    off_d      = off_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    unique case (state_q)
      LSU_IDLE: begin
        if (in_valid) begin
          op_d       = mem_op;
          off_d      = addr[1:0];
          // ren & wen together is treated as a store
          we_d       = mem_wen;
          rdata_d    = '0;
          misalign_d = 1'b0;
          if (!(mem_ren || mem_wen)) begin
            state_d = LSU_DONE;
          end else if (st_misalign) begin
            misalign_d = 1'b1;
            state_d    = LSU_DONE;
          end else begin
            addr_d  = {addr[ADDR_W-1:2], 2'b00};
            wstrb_d = mem_wen ? st_wstrb : 4'b0000;
            wdata_d = mem_wen ? st_wdata : 32'h0;
            state_d = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        if (bus_gnt) begin
          if (bus_rvalid) begin
            rdata_d = we_q ? 32'h0 : ld_data;
            state_d = LSU_DONE;
          end else begin
            state_d = LSU_WAIT;
          end
        end
      end
      LSU_WAIT: begin
        if (bus_rvalid) begin
          rdata_d = we_q ? 32'h0 : ld_data;
          state_d = LSU_DONE;
        end
      end
      LSU_DONE: begin
        if (out_ready) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  assign in_ready     = (state_q == LSU_IDLE);
  assign out_valid    = (state_q == LSU_DONE);
  assign out_rdata    = rdata_q;
  assign out_misalign = misalign_q;
  assign bus_req      = (state_q == LSU_REQ);
  assign bus_we       = we_q & (state_q != LSU_IDLE);
  assign bus_addr     = addr_q;
  assign bus_wstrb    = wstrb_q;
  assign bus_wdata    = wdata_q;

endmodule

// File: tb/tb_ysyx_25030081_lsu.sv
// Self-checking bench for ysyx_25030081_lsu: vector table driven through a
// bus/writeback responder, results checked through an expected-result queue.
module tb_ysyx_25030081_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_ren = 1'b0;
  logic        mem_wen = 1'b0;
  logic [2:0]  mem_op = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic        out_misalign;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  always #5 clk = ~clk;

  ysyx_25030081_lsu #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_ren      (mem_ren),
    .mem_wen      (mem_wen),
    .mem_op       (mem_op),
    .addr         (addr),
    .wdata        (wdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rdata    (out_rdata),
    .out_misalign (out_misalign),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wstrb    (bus_wstrb),
    .bus_wdata    (bus_wdata),
    .bus_gnt      (bus_gnt),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata)
  );

  typedef struct {
    string       name;
    logic        ren;
    logic        wen;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_mis;
    logic [31:0] exp_out;
    logic [3:0]  exp_strb;
    logic [31:0] exp_bwd;
  } vec_t;

  typedef struct {
    logic        mis;
    logic [31:0] rdata;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  localparam logic [31:0] JUNK = 32'hDEAD_0BAD;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input string nm, input logic ren, input logic wen,
                               input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd,
                               input logic mis, input logic [31:0] eo,
                               input logic [3:0] es, input logic [31:0] ew);
    vec_t v;
    v.name = nm; v.ren = ren; v.wen = wen; v.op = op; v.addr = a;
    v.wdata = wd; v.rdata = rd; v.exp_mis = mis; v.exp_out = eo;
    v.exp_strb = es; v.exp_bwd = ew;
    return v;
  endfunction

  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic run(input vec_t v, input int gd, input int rd, input int od, input bit comb);
    bit          goes_bus;
    logic [31:0] baddr;
    exp_t        e;
    goes_bus = (v.ren || v.wen) && !v.exp_mis;
    baddr    = v.addr & 32'hFFFF_FFFC;
    e.mis    = v.exp_mis;
    e.rdata  = v.exp_out;
    sb_q.push_back(e);
    chk({v.name, " in_ready idle"}, {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1; mem_ren = v.ren; mem_wen = v.wen; mem_op = v.op;
    addr = v.addr; wdata = v.wdata;
    @(posedge clk); #1;
    in_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; addr = JUNK; wdata = JUNK;
    if (goes_bus) begin
      for (int c = 0; c <= gd; c++) begin
        if (c == gd) begin
          bus_gnt = 1'b1;
          if (comb) begin bus_rvalid = 1'b1; bus_rdata = v.rdata; end
        end
        @(negedge clk);
        chk({v.name, " bus_req REQ"}, {31'h0, bus_req}, 32'h1);
        chk({v.name, " bus_addr"}, bus_addr, baddr);
        chk({v.name, " bus_we"}, {31'h0, bus_we}, {31'h0, v.wen});
        if (v.wen) begin
          chk({v.name, " bus_wstrb"}, {28'h0, bus_wstrb}, {28'h0, v.exp_strb});
          chk({v.name, " bus_wdata"}, bus_wdata, v.exp_bwd);
        end
        chk({v.name, " out_valid REQ"}, {31'h0, out_valid}, 32'h0);
        chk({v.name, " in_ready REQ"}, {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = JUNK;
      end
      if (!comb) begin
        for (int c = 0; c <= rd; c++) begin
          if (c == rd) begin bus_rvalid = 1'b1; bus_rdata = v.rdata; end
          @(negedge clk);
          chk({v.name, " bus_req WAIT"}, {31'h0, bus_req}, 32'h0);
          chk({v.name, " bus_addr WAIT"}, bus_addr, baddr);
          chk({v.name, " out_valid WAIT"}, {31'h0, out_valid}, 32'h0);
          chk({v.name, " in_ready WAIT"}, {31'h0, in_ready}, 32'h0);
          @(posedge clk); #1;
          bus_rvalid = 1'b0; bus_rdata = JUNK;
        end
      end
    end
    for (int c = 0; c <= od; c++) begin
      if (c == od) out_ready = 1'b1;
      @(negedge clk);
      chk({v.name, " out_valid DONE"}, {31'h0, out_valid}, 32'h1);
      chk({v.name, " in_ready DONE"}, {31'h0, in_ready}, 32'h0);
      chk({v.name, " bus_req DONE"}, {31'h0, bus_req}, 32'h0);
      if (c == od) begin
        if (sb_q.size() == 0) begin
          n_run++; n_fail++;
          $display("FAIL %s scoreboard: result with no expected entry", v.name);
        end else begin
          e = sb_q.pop_front();
          chk({v.name, " out_rdata"}, out_rdata, e.rdata);
          chk({v.name, " out_misalign"}, {31'h0, out_misalign}, {31'h0, e.mis});
        end
      end else begin
        chk({v.name, " out_rdata held"}, out_rdata, v.exp_out);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    @(negedge clk);
    chk({v.name, " out_valid after"}, {31'h0, out_valid}, 32'h0);
    chk({v.name, " in_ready after"}, {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mkv("lb",      1, 0, 3'b000, 32'h8000_0003, 32'h0,         32'h80FF_1234, 0, 32'hFFFF_FF80, 4'h0, 32'h0));
    vecs.push_back(mkv("lbu",     1, 0, 3'b100, 32'h8000_0003, 32'h0,         32'h80FF_1234, 0, 32'h0000_0080, 4'h0, 32'h0));
    vecs.push_back(mkv("sh",      0, 1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h0,         0, 32'h0,         4'b1100, 32'hABCD_ABCD));
    vecs.push_back(mkv("lw_mis",  1, 0, 3'b010, 32'h8000_0001, 32'h0,         32'h0,         1, 32'h0,         4'h0, 32'h0));
    vecs.push_back(mkv("nonmem",  0, 0, 3'b010, 32'h8000_0001, 32'h5555_5555, 32'h0,         0, 32'h0,         4'h0, 32'h0));
    vecs.push_back(mkv("lh",      1, 0, 3'b001, 32'h8000_0002, 32'h0,         32'h80FF_1234, 0, 32'hFFFF_80FF, 4'h0, 32'h0));
    vecs.push_back(mkv("lhu",     1, 0, 3'b101, 32'h8000_0002, 32'h0,         32'h80FF_1234, 0, 32'h0000_80FF, 4'h0, 32'h0));
    vecs.push_back(mkv("sw",      0, 1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0,         0, 32'h0,         4'b1111, 32'hDEAD_BEEF));
    vecs.push_back(mkv("sb",      0, 1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'h0,         0, 32'h0,         4'b0010, 32'hA5A5_A5A5));
    vecs.push_back(mkv("lw",      1, 0, 3'b010, 32'h8000_0004, 32'h0,         32'h1234_5678, 0, 32'h1234_5678, 4'h0, 32'h0));
    vecs.push_back(mkv("sh_mis",  0, 1, 3'b001, 32'h8000_0003, 32'h1111_2222, 32'h0,         1, 32'h0,         4'h0, 32'h0));
    vecs.push_back(mkv("rw_both", 1, 1, 3'b000, 32'h8000_0020, 32'h0000_0011, 32'h7777_7777, 0, 32'h0,         4'b0001, 32'h1111_1111));
    vecs.push_back(mkv("op110",   1, 0, 3'b110, 32'h8000_0008, 32'h0,         32'h8765_4321, 0, 32'h8765_4321, 4'h0, 32'h0));
    vecs.push_back(mkv("op111m",  1, 0, 3'b111, 32'h8000_0002, 32'h0,         32'h0,         1, 32'h0,         4'h0, 32'h0));
    vecs.push_back(mkv("op011",   1, 0, 3'b011, 32'h8000_000C, 32'h0,         32'hCAFE_F00D, 0, 32'hCAFE_F00D, 4'h0, 32'h0));
    vecs.push_back(mkv("lb_pos",  1, 0, 3'b000, 32'h8000_0001, 32'h0,         32'h0000_7F00, 0, 32'h0000_007F, 4'h0, 32'h0));
    vecs.push_back(mkv("sh0",     0, 1, 3'b101, 32'h8000_0000, 32'hFFFF_8001, 32'h0,         0, 32'h0,         4'b0011, 32'h8001_8001));

    #2;
    chk("rst in_ready",     {31'h0, in_ready},     32'h1);
    chk("rst out_valid",    {31'h0, out_valid},    32'h0);
    chk("rst out_misalign", {31'h0, out_misalign}, 32'h0);
    chk("rst out_rdata",    out_rdata,             32'h0);
    chk("rst bus_req",      {31'h0, bus_req},      32'h0);
    chk("rst bus_we",       {31'h0, bus_we},       32'h0);
    chk("rst bus_addr",     bus_addr,              32'h0);
    chk("rst bus_wstrb",    {28'h0, bus_wstrb},    32'h0);
    chk("rst bus_wdata",    bus_wdata,             32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run(vecs[i], 0, 0, 0, 1'b0);

    // Stalls on gnt, rvalid and out_ready, then combined gnt+rvalid.
    run(vecs[0], 3, 2, 2, 1'b0);
    run(vecs[2], 3, 2, 2, 1'b0);
    run(vecs[9], 0, 0, 0, 1'b1);
    run(vecs[7], 2, 0, 1, 1'b1);
    run(vecs[3], 0, 0, 2, 1'b0);

    // Stray bus responses in IDLE are ignored.
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = JUNK;
    @(posedge clk); #1;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    chk("stray out_valid", {31'h0, out_valid}, 32'h0);
    chk("stray in_ready",  {31'h0, in_ready},  32'h1);
    chk("stray bus_req",   {31'h0, bus_req},   32'h0);
    @(posedge clk); #1;

    // Reset asserted while in WAIT; a late rvalid afterwards is ignored.
    in_valid = 1'b1; mem_ren = 1'b1; mem_op = 3'b010; addr = 32'h8000_0008;
    @(posedge clk); #1;
    in_valid = 1'b0; mem_ren = 1'b0; bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(negedge clk);
    chk("mid bus_addr WAIT", bus_addr, 32'h8000_0008);
    chk("mid in_ready WAIT", {31'h0, in_ready}, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid rst bus_req",   {31'h0, bus_req},   32'h0);
    chk("mid rst out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid rst in_ready",  {31'h0, in_ready},  32'h1);
    chk("mid rst bus_addr",  bus_addr,           32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("late rvalid out_valid", {31'h0, out_valid}, 32'h0);
      chk("late rvalid in_ready",  {31'h0, in_ready},  32'h1);
    end
    @(posedge clk); #1;
    run(vecs[1], 1, 1, 0, 1'b0);

    if (sb_q.size() != 0) begin
      n_run++; n_fail++;
      $display("FAIL scoreboard drain: %0d expected results never produced", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
